// File: rtl/logic_gate_pkg.sv
// Shared definitions for the gate blocks: the op select type and its encodings.
package logic_gate_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'b000;
    localparam op_t OP_OR   = 3'b001;
    localparam op_t OP_XOR  = 3'b010;
    localparam op_t OP_XNOR = 3'b011;
    localparam op_t OP_NAND = 3'b100;
    localparam op_t OP_NOR  = 3'b101;
    localparam op_t OP_NOTA = 3'b110;
    localparam op_t OP_BUF  = 3'b111;

endpackage

// File: rtl/logic_gate_core.sv
// Combinational bitwise gate: Y = f(Op, A, B) across all WIDTH bits.
module logic_gate_core
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y
);

    // Select one of the eight bitwise functions; the last two ignore B.
    always_comb begin
        Y = '0;
        unique case (Op)
            OP_AND:  Y = A & B;
            OP_OR:   Y = A | B;
            OP_XOR:  Y = A ^ B;
            OP_XNOR: Y = ~(A ^ B);
            OP_NAND: Y = ~(A & B);
            OP_NOR:  Y = ~(A | B);
            OP_NOTA: Y = ~A;
            OP_BUF:  Y = A;
        endcase
    end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered gate element with valid/ready handshake and a saturating
// count of accepted operand pairs that were equal.
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  op_t              Op,
    input  logic             InValid,
    output logic             InReady,
    output logic [WIDTH-1:0] Out,
    output logic             Eq,
    output logic             OutValid,
    input  logic             OutReady,
    input  logic             ClrCount,
    output logic [CNT_W-1:0] MatchCount
);

    logic [WIDTH-1:0] gate_y;
    logic [WIDTH-1:0] out_q, out_d;
    logic             eq_q, eq_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, consume, match;

    logic_gate_core #(.WIDTH(WIDTH)) u_core (
        .Op (Op),
        .A  (A),
        .B  (B),
        .Y  (gate_y)
    );

    // Skid-free single register: ready whenever the slot is empty or draining.
    assign InReady = !out_valid_q || OutReady;
    assign accept  = InValid && InReady;
    assign consume = out_valid_q && OutReady;
    assign match   = (A == B);

    // Next-state for result register, valid flag and match counter.
    always_comb begin
        out_d       = out_q;
        eq_d        = eq_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        if (accept) begin
            out_d       = gate_y;
            eq_d        = match;
            out_valid_d = 1'b1;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
        // Clear wins over a matching accept in the same cycle.
        if (ClrCount) begin
            cnt_d = '0;
        end else if (accept && match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset discards any held result.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_q       <= '0;
            eq_q        <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_q       <= out_d;
            eq_q        <= eq_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign Out        = out_q;
    assign Eq         = eq_q;
    assign OutValid   = out_valid_q;
    assign MatchCount = cnt_q;

endmodule
